// File: rtl/som_ram_pkg.sv
// Shared types and defaults for the SOM RAM burst controller.
package som_ram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 24;
  localparam int DEF_LEN_W  = 12;
  localparam int RAM_DEPTH  = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // A read may be issued only if the word it returns is guaranteed a buffer slot.
  function automatic logic issue_ok(input logic [1:0] count, input logic pending, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, count} + {2'b00, pending} - {2'b00, pop};
    return (occ < 3'd2);
  endfunction

endpackage

// File: rtl/som_rd_fifo2.sv
// Two-entry read-data buffer; head word is presented straight from a register.
module som_rd_fifo2
  import som_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count
);

  logic [1:0][DATA_W-1:0] mem_q, mem_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   push_ok_s, pop_ok_s;

  // next-state for storage, pointers and occupancy
  always_comb begin
    pop_ok_s  = pop && (count_q != 2'd0);
    push_ok_s = push && ((count_q != 2'd2) || pop_ok_s);
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/som_ram_ctrl.sv
// Burst read/write initiator for the single-port SOM RAM; every RAM pin is a flop,
// read data returns through a two-entry buffer so reads stream at one word per cycle.
module som_ram_ctrl
  import som_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              CK,
  input  logic              RST_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic [ADDR_W-1:0] A,
  output logic              WE,
  output logic              OE,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  localparam int                REM_W    = LEN_W + 1;
  localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  d_q, d_d;
  logic               pending_q, pending_d;
  logic               we_q, we_d;
  logic               oe_q, oe_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               wdata_ready_q, wdata_ready_d;

  logic [1:0]         fifo_count_s;
  logic               rdata_valid_s, pop_s, wr_hs_s, issue_s;

  som_rd_fifo2 #(.DATA_W(DATA_W)) u_rd_fifo (
    .clk       (CK),
    .rst_n     (RST_N),
    .push      (pending_q),
    .push_data (Q),
    .pop       (pop_s),
    .pop_data  (rdata),
    .count     (fifo_count_s)
  );

  assign rdata_valid_s = (fifo_count_s != 2'd0);
  assign pop_s         = rdata_valid_s && rdata_ready;
  assign wr_hs_s       = (state_q == WRITE) && wdata_ready_q && wdata_valid;
  assign issue_s       = (state_q == READ) && issue_ok(fifo_count_s, pending_q, pop_s);

  // burst sequencing and next values of every registered RAM pin
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    a_d       = a_q;
    d_d       = d_q;
    pending_d = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // we_q still high here means the last write of a burst is committing now
        done_d = we_q;
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          rem_d   = {1'b0, cmd_len} + REM_ONE;
          state_d = cmd_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (wr_hs_s) begin
          a_d    = addr_q;
          d_d    = wdata;
          we_d   = 1'b1;
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - REM_ONE;
          state_d = (rem_q == REM_ONE) ? IDLE : WRITE;
        end else begin
          state_d = WRITE;
        end
      end
      READ: begin
        if (issue_s) begin
          a_d       = addr_q;
          pending_d = 1'b1;
          addr_d    = addr_q + ADDR_ONE;
          rem_d     = rem_q - REM_ONE;
          state_d   = (rem_q == REM_ONE) ? DRAIN : READ;
        end else begin
          state_d = READ;
        end
      end
      DRAIN: begin
        if (!pending_q && ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    oe_d          = (state_d == READ) || (state_d == DRAIN);
    cmd_ready_d   = (state_d == IDLE);
    wdata_ready_d = (state_d == WRITE) && (rem_d != '0);
  end

  // FSM and output registers, synchronous active-low reset
  always_ff @(posedge CK) begin
    if (!RST_N) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rem_q         <= '0;
      a_q           <= '0;
      d_q           <= '0;
      pending_q     <= 1'b0;
      we_q          <= 1'b0;
      oe_q          <= 1'b0;
      done_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      a_q           <= a_d;
      d_q           <= d_d;
      pending_q     <= pending_d;
      we_q          <= we_d;
      oe_q          <= oe_d;
      done_q        <= done_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign wdata_ready = wdata_ready_q;
  assign rdata_valid = rdata_valid_s;
  assign done        = done_q;
  assign A           = a_q;
  assign WE          = we_q;
  assign OE          = oe_q;
  assign D           = d_q;

endmodule

// File: tb/tb_som_ram_ctrl.sv
// Scoreboard bench for som_ram_ctrl: stimulus pushes expected RAM writes, read words
// and done cycles; a negedge monitor pops and compares as the DUT presents them.
module tb_som_ram_ctrl;
  import som_ram_pkg::*;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 24;
  localparam int LEN_W  = 12;
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic              CK = 1'b0;
  logic              RST_N = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              wdata_valid = 1'b0, wdata_ready;
  logic [DATA_W-1:0] wdata = '0;
  logic              rdata_valid, rdata_ready = 1'b1;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic [ADDR_W-1:0] A;
  logic              WE, OE;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;

  som_ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CK(CK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .done(done), .A(A), .WE(WE), .OE(OE), .D(D), .Q(Q)
  );

  always #5 CK = ~CK;

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  // RAM model: address latched on the falling edge, write committed there too
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram[i] = '0;
  end
  always @(negedge CK) begin
    if (WE === 1'b1) ram[A[RAM_AW-1:0]] = D;
    Q = ram[A[RAM_AW-1:0]];
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct { int cyc; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } wr_exp_t;
  typedef struct { int cyc; logic [DATA_W-1:0] d; } rd_exp_t;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];
  int      done_exp[$];   // -1: cycle after the most recent rdata pop
  int      last_pop_cyc = 0;
  int      done_cnt = 0;
  int      oe_cnt = 0;

  // monitor: compare everything the DUT presents against the scoreboard
  always @(negedge CK) begin
    wr_exp_t we_e;
    rd_exp_t rd_e;
    int      de;
    if (WE === 1'b1 || OE === 1'b1) chk("we_oe_exclusive", 32'(WE & OE), 32'd0);
    if (OE === 1'b1) oe_cnt++;
    if (WE === 1'b1) begin
      chk("we_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        we_e = wr_q.pop_front();
        chk("we_cycle", cyc, we_e.cyc);
        chk("we_addr", 32'(A), 32'(we_e.a));
        chk("we_data", 32'(D), 32'(we_e.d));
      end
    end
    if (rdata_valid === 1'b1 && rdata_ready === 1'b1) begin
      chk("rdata_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        rd_e = rd_q.pop_front();
        if (rd_e.cyc >= 0) chk("rdata_cycle", cyc, rd_e.cyc);
        chk("rdata_value", 32'(rdata), 32'(rd_e.d));
      end
      last_pop_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("done_expected", 32'(done_exp.size() != 0), 32'd1);
      if (done_exp.size() != 0) begin
        de = done_exp.pop_front();
        chk("done_cycle", cyc, (de >= 0) ? de : last_pop_cyc + 1);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_A"}, 32'(A), 32'd0);
    chk({tag, "_D"}, 32'(D), 32'd0);
    chk({tag, "_WE"}, 32'(WE), 32'd0);
    chk({tag, "_OE"}, 32'(OE), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_rdata_valid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_wdata_ready"}, 32'(wdata_ready), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_done(input int t0, input int budget);
    int k = 0;
    while (done_cnt == t0 && k < budget) begin
      @(posedge CK); #1;
      k++;
    end
    chk("done_within_budget", 32'(done_cnt != t0), 32'd1);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input int n, input logic [DATA_W-1:0] base);
    int      acc, t0;
    wr_exp_t e;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = LEN_W'(n - 1);
    @(posedge CK); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.cyc = acc + 1 + i;
      e.a   = addr + ADDR_W'(i);
      e.d   = base + DATA_W'(i);
      wr_q.push_back(e);
    end
    done_exp.push_back(acc + n + 1);
    t0 = done_cnt;
    for (int i = 0; i < n; i++) begin
      wdata_valid = 1'b1;
      wdata = base + DATA_W'(i);
      @(posedge CK); #1;
    end
    wdata_valid = 1'b0;
    wait_done(t0, 20);
  endtask

  // toggle=0: rdata_ready held high and exact cycles checked; toggle=1: ready 1,0,0,...
  task automatic do_read(input logic [ADDR_W-1:0] addr, input int n, input logic [DATA_W-1:0] base,
                         input bit toggle);
    int      acc, t0, oe0, k;
    rd_exp_t e;
    rdata_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = LEN_W'(n - 1);
    @(posedge CK); #1;
    acc = cyc;
    oe0 = oe_cnt;
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.cyc = toggle ? -1 : acc + 2 + i;
      e.d   = base + DATA_W'(i);
      rd_q.push_back(e);
    end
    done_exp.push_back(toggle ? -1 : acc + n + 2);
    t0 = done_cnt;
    k = 0;
    while (done_cnt == t0 && k < 80) begin
      rdata_ready = toggle ? ((k % 3) == 0) : 1'b1;
      @(posedge CK); #1;
      k++;
    end
    chk("read_done_within_budget", 32'(done_cnt != t0), 32'd1);
    if (!toggle) chk("read_oe_cycles", oe_cnt - oe0, n + 2);
    rdata_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, t0;
    rd_exp_t e;

    // reset behaviour from the very first edge
    @(posedge CK); #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge CK);
    #1;
    RST_N = 1'b1;
    @(posedge CK); #1;

    // 4-word write, RAM contents, then timed read-back
    do_write(18'h00010, 4, 24'h000011);
    for (int i = 0; i < 4; i++) chk("ram_content", 32'(ram[12'h010 + i]), 32'h11 + 32'(i));
    do_read(18'h00010, 4, 24'h000011, 1'b0);

    // extend to 6 words, then read them with back-pressure
    do_write(18'h00014, 2, 24'h000015);
    do_read(18'h00010, 6, 24'h000011, 1'b1);

    // address wrap on write and read
    do_write(18'h3FFFF, 2, 24'hBEEF01);
    chk("ram_wrap_hi", 32'(ram[12'hFFF]), 32'hBEEF01);
    chk("ram_wrap_lo", 32'(ram[12'h000]), 32'hBEEF02);
    do_read(18'h3FFFF, 2, 24'hBEEF01, 1'b0);

    // single-word bursts
    do_write(18'h00020, 1, 24'h123456);
    do_read(18'h00020, 1, 24'h123456, 1'b0);

    // reset in the middle of a 5-word read, after two words are delivered
    rdata_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h00010; cmd_len = 12'd4;
    @(posedge CK); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e.cyc = acc + 2 + i;
      e.d   = 24'h000011 + DATA_W'(i);
      rd_q.push_back(e);
    end
    t0 = done_cnt;
    repeat (3) @(posedge CK);
    #1;
    RST_N = 1'b0;
    @(posedge CK); #1;
    check_reset_outputs("midreset");
    RST_N = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    chk("no_done_after_reset", done_cnt, t0);
    chk("rd_q_drained_after_reset", rd_q.size(), 0);

    // fresh command after the abandoned burst
    do_read(18'h00010, 1, 24'h000011, 1'b0);

    repeat (3) @(posedge CK);
    #1;
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
    chk("done_exp_empty", done_exp.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/som_ram_ctrl.md
# som_ram_ctrl

Burst-access initiator for the single-port RAM used by the SOM processing system. It accepts read or write burst commands from the SOM datapath over a valid/ready handshake. It drives the RAM pins (A, WE, OE, D) and streams read data back through a 2-entry output buffer, so reads run at one word per cycle with back-pressure. It is the only master on the RAM bus.

## Interface
- ADDR_W, 18, RAM address width
- DATA_W, 24, RAM word width
- LEN_W, 12, burst length field width; burst covers cmd_len+1 words
- CK  input  1  clock; all state updates on rising edge
- RST_N  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_W  first word address
- cmd_len  input  LEN_W  words minus one
- wdata_valid  input  1  write word offered
- wdata_ready  output  1  high in WRITE while words remain
- wdata  input  DATA_W  write word
- rdata_valid  output  1  output buffer non-empty
- rdata_ready  input  1  consumer accepts rdata
- rdata  output  DATA_W  head of output buffer
- done  output  1  one-cycle pulse at burst completion
- A  output  ADDR_W  RAM address, registered
- WE  output  1  RAM write enable, registered
- OE  output  1  RAM read enable, registered
- D  output  DATA_W  RAM write data, registered
- Q  input  DATA_W  RAM read data

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_valid && cmd_ready latches addr, remaining = cmd_len+1, direction.
  - cmd_write=1 goes to WRITE; cmd_write=0 goes to READ.
- WRITE: each wdata handshake registers A=addr, D=wdata, WE=1 for exactly that cycle. Then addr+=1 and remaining-=1. The last handshake goes to IDLE.
- READ:
  - OE=1 throughout READ and DRAIN.
  - Issue condition: (buffer count + pending - pop_this_cycle) < 2.
  - On issue: A=addr, pending=1, addr+=1, remaining-=1.
  - Next rising edge: Q is pushed into the buffer if pending; pending then takes the new issue decision.
  - After the last issue, go to DRAIN.
- DRAIN: wait until pending=0 and the buffer is empty, then go to IDLE.
- Address arithmetic is modulo 2^ADDR_W; 0x3FFFF+1 wraps to 0x00000. The RAM decodes only the low 12 bits.
- WE and OE are never high together. WE=0 and OE=0 in IDLE.
- A and D hold their last value when not updated.
- Buffer push and pop in the same cycle keep the count unchanged. Order is preserved.
- done pulses:
  - Write burst: the cycle after the last WE cycle, when the RAM has committed the word.
  - Read burst: the cycle after the last word leaves the buffer.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

## Timing
- Reset (RST_N low at a rising edge) forces:
  - state=IDLE; pending=0; buffer empty; remaining=0.
  - A=0, D=0, WE=0, OE=0, done=0.
  - rdata_valid=0, wdata_ready=0.
  - cmd_ready=1 from the first edge with RST_N low.
- Reset mid-burst abandons the burst with no done pulse. A WE already registered is cleared at the same edge, so no further RAM write occurs.
- The RAM latches A on the falling edge of CK, and Q is valid before the next rising edge. Read latency is therefore:
  - issue edge → 1 cycle → buffer;
  - rdata_valid rises 1 cycle after issue.
- Throughput with rdata_ready held high: one word per cycle. An N-word read completes in N+2 cycles from command accept to done.
- Write: one word per cycle while wdata_valid is held. The RAM writes on the edge after the handshake.
- Command accept to first WE or issue: 1 cycle.
- No combinational path from Q to any output except through the buffer registers.

## Structure
- Package som_ram_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - default widths ADDR_W=18, DATA_W=24, LEN_W=12;
  - RAM_DEPTH=4096.
- Sub-module som_rd_fifo2: 2-entry synchronous FIFO with push/pop/count, synchronous active-low reset, count output for the issue check.

## Test plan
- Write 4 words 0x000011..0x000014 at addr 0x010 (len=3). Expect:
  - WE high for 4 consecutive cycles with A=0x010..0x013;
  - done pulse 1 cycle after the last WE;
  - RAM contents match.
- Read the same 4 words with rdata_ready=1. Expect:
  - rdata 0x000011..0x000014 on 4 consecutive cycles starting 2 cycles after accept;
  - done after the last pop;
  - OE high, WE low throughout.
- Read 6 words with rdata_ready toggling 1,0,0,1,…. Expect no data loss or duplication, buffer count never exceeding 2, and A stalled while the buffer is full.
- Write len=1 at addr 0x3FFFF. Expect A=0x3FFFF then 0x00000, i.e. wrap-around.
- len=0 single-word read and single-word write. Expect exactly one RAM access each and done asserted once.
- Assert RST_N low mid-read (2 of 5 words delivered). Expect outputs at reset values next cycle, no done pulse, and a fresh command accepted normally afterwards.
